// File: rtl/serial_mult_feeder.sv
// Feeder/checker for an external bit-serial multiplier: latches an operand
// pair, streams it LSB first, waits LAT cycles, collects the 2*WIDTH-bit
// product LSB first and flags any mismatch against an internal multiply.
module serial_mult_feeder #(
  parameter int WIDTH = 8,
  parameter int LAT   = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 ser_start,
  output logic                 ser_a,
  output logic                 ser_b,
  input  logic                 ser_p,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   res_p,
  output logic                 res_err,
  output logic [5:0]           status
);

  localparam int CW = ($clog2(2*WIDTH) > 4) ? $clog2(2*WIDTH) : 4;
  localparam logic [CW-1:0] LAST_OP   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(LAT - 1);
  localparam logic [CW-1:0] LAST_P    = CW'(2*WIDTH - 1);
  localparam logic [4:0]    CNT_MAX   = 5'd29;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_OP,
    WAIT,
    SHIFT_P,
    HOLD
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     lat_a;
  logic [WIDTH-1:0]     lat_b;
  logic [WIDTH-1:0]     shift_a;
  logic [WIDTH-1:0]     shift_b;
  logic [2*WIDTH-1:0]   shift_p;
  logic [2*WIDTH-1:0]   shift_p_next;
  logic [2*WIDTH-1:0]   ref_p;
  logic                 err_sticky;
  logic [4:0]           done_cnt;

  // Acceptance is gated by reset so the block never advertises ready under reset.
  assign op_ready = (state == IDLE) && !wb_rst_i;
  assign status   = {err_sticky, done_cnt};

  // Next product shift value and the reference product of the latched operands.
  always_comb begin
    shift_p_next = {ser_p, shift_p[2*WIDTH-1:1]};
    ref_p        = (2*WIDTH)'(lat_a) * (2*WIDTH)'(lat_b);
  end

  // Frame sequencer with registered serial and result outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_a      <= '0;
      lat_b      <= '0;
      shift_a    <= '0;
      shift_b    <= '0;
      shift_p    <= '0;
      ser_start  <= 1'b0;
      ser_a      <= 1'b0;
      ser_b      <= 1'b0;
      res_valid  <= 1'b0;
      res_p      <= '0;
      res_err    <= 1'b0;
      err_sticky <= 1'b0;
      done_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            lat_a     <= op_a;
            lat_b     <= op_b;
            ser_start <= 1'b1;
            ser_a     <= op_a[0];
            ser_b     <= op_b[0];
            shift_a   <= op_a >> 1;
            shift_b   <= op_b >> 1;
            cnt       <= '0;
            state     <= SHIFT_OP;
          end
        end
        SHIFT_OP: begin
          ser_start <= 1'b0;
          if (cnt == LAST_OP) begin
            ser_a <= 1'b0;
            ser_b <= 1'b0;
            cnt   <= '0;
            state <= WAIT;
          end else begin
            ser_a   <= shift_a[0];
            ser_b   <= shift_b[0];
            shift_a <= shift_a >> 1;
            shift_b <= shift_b >> 1;
            cnt     <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (cnt == LAST_WAIT) begin
            cnt   <= '0;
            state <= SHIFT_P;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT_P: begin
          shift_p <= shift_p_next;
          if (cnt == LAST_P) begin
            res_p     <= shift_p_next;
            res_err   <= (shift_p_next != ref_p);
            if (shift_p_next != ref_p) begin
              err_sticky <= 1'b1;
            end
            res_valid <= 1'b1;
            cnt       <= '0;
            state     <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (done_cnt != CNT_MAX) begin
              done_cnt <= done_cnt + 5'd1;
            end
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mult_feeder.sv
// Scoreboard bench for serial_mult_feeder: a behavioural serial multiplier
// model answers each frame, a monitor checks results against queued
// expectations, and the stimulus process issues operand pairs.
module tb_serial_mult_feeder;

  localparam int W = 8;
  localparam int L = 2;
  // Edges from the accepting edge to the first cycle with res_valid=1.
  localparam int LATENCY = W + L + 2*W;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] mask;
  } op_t;

  typedef struct {
    logic [2*W-1:0] p;
    logic           err;
    int             stall;
    int             t_acc;
  } res_t;

  logic           clk;
  logic           rst;
  logic           op_valid;
  logic           op_ready;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           ser_start;
  logic           ser_a;
  logic           ser_b;
  logic           ser_p;
  logic           res_valid;
  logic           res_ready;
  logic [2*W-1:0] res_p;
  logic           res_err;
  logic [5:0]     status;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  op_t  op_q[$];
  res_t sb[$];
  bit   in_hold = 0;

  serial_mult_feeder #(.WIDTH(W), .LAT(L)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .ser_start (ser_start),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_p     (ser_p),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_p     (res_p),
    .res_err   (res_err),
    .status    (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_op_ready"},  64'(op_ready),  64'(0));
    check({tag, "_res_valid"}, 64'(res_valid), 64'(0));
    check({tag, "_ser_start"}, 64'(ser_start), 64'(0));
    check({tag, "_ser_a"},     64'(ser_a),     64'(0));
    check({tag, "_ser_b"},     64'(ser_b),     64'(0));
    check({tag, "_res_err"},   64'(res_err),   64'(0));
    check({tag, "_res_p"},     64'(res_p),     64'(0));
    check({tag, "_status"},    64'(status),    64'(0));
  endtask

  // Serial multiplier model: collects operand bits, returns their product
  // (optionally corrupted) LSB first after LAT idle cycles, noise otherwise.
  initial begin
    int             mph;
    logic [W-1:0]   ca;
    logic [W-1:0]   cb;
    logic [2*W-1:0] prod;
    op_t            o;
    mph  = -1;
    ca   = '0;
    cb   = '0;
    prod = '0;
    ser_p = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mph   = -1;
        ser_p = 1'b0;
        continue;
      end
      if (mph < 0 && ser_start) mph = 0;
      if (mph >= 1) check("ser_start_once", 64'(ser_start), 64'(0));
      if (mph >= 0 && mph < W) begin
        ca[mph] = ser_a;
        cb[mph] = ser_b;
        if (mph == W - 1) begin
          if (op_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL model_no_op: got=frame expected=none (cycle %0d)", cyc);
            prod = '0;
          end else begin
            o = op_q.pop_front();
            check("ser_a_bits", 64'(ca), 64'(o.a));
            check("ser_b_bits", 64'(cb), 64'(o.b));
            prod = ((2*W)'(ca) * (2*W)'(cb)) ^ o.mask;
          end
        end
      end else begin
        check("ser_a_idle", 64'(ser_a), 64'(0));
        check("ser_b_idle", 64'(ser_b), 64'(0));
      end
      if (mph >= W + L && mph < W + L + 2*W) ser_p = prod[mph - W - L];
      else ser_p = 1'($urandom);
      if (mph >= 0) begin
        mph++;
        if (mph == W + L + 2*W) mph = -1;
      end
    end
  end

  // Result monitor: pops the scoreboard on each new result, checks hold
  // stability, applies the planned backpressure and checks the handshake.
  initial begin
    res_t       cur;
    int         stall;
    bit         hs_pend;
    bit         exp_sticky;
    logic [4:0] exp_count;
    res_ready  = 1'b0;
    hs_pend    = 0;
    stall      = 0;
    exp_sticky = 0;
    exp_count  = '0;
    cur        = '{p: '0, err: 1'b0, stall: 0, t_acc: 0};
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        in_hold    = 0;
        hs_pend    = 0;
        exp_sticky = 0;
        exp_count  = '0;
        res_ready  = 1'b0;
        continue;
      end
      if (in_hold && hs_pend) begin
        check("hs_res_valid", 64'(res_valid), 64'(0));
        check("hs_op_ready",  64'(op_ready),  64'(1));
        check("hs_res_p_kept", 64'(res_p), 64'(cur.p));
        exp_count = (exp_count < 5'd29) ? exp_count + 5'd1 : 5'd29;
        check("hs_status", 64'(status), 64'({exp_sticky, exp_count}));
        in_hold = 0;
        hs_pend = 0;
      end else if (in_hold) begin
        check("hold_res_valid", 64'(res_valid), 64'(1));
        check("hold_res_p",     64'(res_p),     64'(cur.p));
        check("hold_res_err",   64'(res_err),   64'(cur.err));
        check("hold_op_ready",  64'(op_ready),  64'(0));
      end else if (res_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got res_p=%0h expected=no result (cycle %0d)", res_p, cyc);
          cur = '{p: res_p, err: res_err, stall: 0, t_acc: cyc};
        end else begin
          cur = sb.pop_front();
          exp_sticky = exp_sticky | cur.err;
          check("res_p",     64'(res_p),     64'(cur.p));
          check("res_err",   64'(res_err),   64'(cur.err));
          check("latency",   64'(cyc - cur.t_acc), 64'(LATENCY));
          check("hold_status", 64'(status), 64'({exp_sticky, exp_count}));
          check("first_op_ready", 64'(op_ready), 64'(0));
        end
        in_hold = 1;
        stall   = cur.stall;
      end
      if (in_hold && !hs_pend) begin
        if (stall == 0) begin
          res_ready = 1'b1;
          hs_pend   = 1;
        end else begin
          res_ready = 1'b0;
          stall--;
        end
      end else if (!in_hold) begin
        res_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] mask, input int stall, input bit want);
    int waited;
    logic [2*W-1:0] full;
    logic [2*W-1:0] ret;
    waited = 0;
    while (!op_ready && waited < 200) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (!op_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got op_ready=0 expected=1 within 200 cycles (cycle %0d)", cyc);
      return;
    end
    op_q.push_back('{a: a, b: b, mask: mask});
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    @(posedge clk);
    #2;
    op_valid = 1'b0;
    op_a     = W'($urandom);
    op_b     = W'($urandom);
    full = (2*W)'(a) * (2*W)'(b);
    ret  = full ^ mask;
    if (want) sb.push_back('{p: ret, err: (ret != full), stall: stall, t_acc: cyc});
  endtask

  // Stimulus: reset, directed operations, random back-to-back run, mid-frame reset.
  initial begin
    int waited;
    logic [2*W-1:0] mask;
    rst      = 1'b1;
    op_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      check_all_zero("reset");
    end
    rst = 1'b0;
    #1;
    check("release_op_ready", 64'(op_ready), 64'(1));

    issue(8'h0D, 8'h0B, '0, 0, 1);
    issue(8'h0D, 8'h0B, 16'h008F ^ 16'h0090, 0, 1);
    issue(8'hFF, 8'hFF, '0, 0, 1);
    issue(W'($urandom), W'($urandom), '0, 10, 1);
    for (int i = 0; i < 31; i++) begin
      mask = ($urandom_range(0, 3) == 0) ? (2*W)'($urandom_range(1, 65535)) : '0;
      issue(W'($urandom), W'($urandom), mask, $urandom_range(0, 3), 1);
    end

    // Reset lands while the product is streaming in (SHIFT_P cycle 5).
    issue(W'($urandom), W'($urandom), '0, 0, 0);
    repeat (W + L + 5) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    check_all_zero("midreset");
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_op_ready", 64'(op_ready), 64'(1));
    issue(8'h03, 8'h05, '0, 0, 1);

    waited = 0;
    while ((sb.size() != 0 || in_hold) && waited < 200) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (sb.size() != 0 || in_hold) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got pending=%0d expected=0", sb.size());
    end
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_mult_feeder.md
SERIAL_MULT_FEEDER -- requirements
Module: serial_mult_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits.
REQ-002 The block SHALL have parameter LAT, default 2, range 1-15, giving the idle cycles between the last operand bit and the first product bit.
REQ-003 wb_clk_i  input  1  sole clock; all state changes on the rising edge.
REQ-004 wb_rst_i  input  1  reset; synchronous and active-high.
REQ-005 op_valid  input  1  operand pair offered.
REQ-006 op_ready  output  1  block accepts an operand pair.
REQ-007 op_a, op_b  input  WIDTH each  unsigned operands.
REQ-008 ser_start  output  1  one-cycle frame strobe to the serial multiplier.
REQ-009 ser_a, ser_b  output  1 each  operand bits, LSB first.
REQ-010 ser_p  input  1  product bit from the multiplier, LSB first.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  result consumed.
REQ-013 res_p  output  2*WIDTH  captured product.
REQ-014 res_err  output  1  res_p differs from the internal op_a*op_b.
REQ-015 status  output  6  bit 5 is the sticky error flag; bits 4:0 are the completed-operation count.

Function
REQ-016 The FSM SHALL have states IDLE, SHIFT_OP (WIDTH cycles), WAIT (LAT cycles), SHIFT_P (2*WIDTH cycles) and HOLD.
REQ-017 op_ready SHALL be 1 only in IDLE; in IDLE, op_valid=1 SHALL latch op_a/op_b and move to SHIFT_OP at that edge.
REQ-018 ser_start SHALL be 1 only in the first SHIFT_OP cycle.
REQ-019 In SHIFT_OP cycle i (i=0..WIDTH-1), ser_a/ser_b SHALL carry bit i of the latched operands; in all other states they SHALL be 0.
REQ-020 WAIT SHALL last exactly LAT cycles, then move to SHIFT_P.
REQ-021 In SHIFT_P cycle j (j=0..2*WIDTH-1), ser_p SHALL be sampled as product bit j; after the last sample the FSM SHALL move to HOLD.
REQ-022 res_valid SHALL be 1 only in HOLD.
REQ-023 res_p and res_err SHALL be stable throughout HOLD; res_err SHALL equal (captured product != latched op_a*op_b, full 2*WIDTH-bit compare).
REQ-024 Latency: with accept at edge T, res_valid SHALL first be 1 in cycle T+1+WIDTH+LAT+2*WIDTH (T+27 at defaults).
REQ-025 In HOLD, res_ready=1 SHALL complete the result handshake and move to IDLE, so op_ready=1 on the next cycle; operations SHALL NOT overlap.
REQ-026 status[5] SHALL be set on entry to HOLD when res_err=1 and SHALL remain set until reset.
REQ-027 status[4:0] SHALL increment at each result handshake and saturate at 29; codes 30 and 31 are reserved for the pass and begin stage codes.
REQ-028 res_p SHALL hold its last value outside HOLD and SHALL NOT be cleared on the handshake.
REQ-029 The ser_p value SHALL be ignored outside SHIFT_P.
REQ-030 op_valid SHALL be ignored outside IDLE.
REQ-031 res_ready SHALL be ignored outside HOLD.

Reset
REQ-032 wb_rst_i=1 at an edge SHALL force IDLE in every state, including mid-SHIFT_OP, WAIT and SHIFT_P; any partial product SHALL be discarded.
REQ-033 Under reset, res_valid, ser_start, ser_a, ser_b, res_err, res_p and status SHALL all be 0.
REQ-034 op_ready SHALL be 0 while wb_rst_i=1 and SHALL be 1 in the first cycle after release.
REQ-035 Reset SHALL take priority over a simultaneous op_valid or res_ready.

Verification
REQ-036 Reset: hold wb_rst_i 3 cycles -> all outputs 0; op_ready=1 in the first cycle after release.
REQ-037 Good multiply: op_a=0x0D, op_b=0x0B, model returns 0x008F, accept at T -> ser_a=1,0,1,1,0,0,0,0 and ser_b=1,1,0,1,0,0,0,0 in cycles T+1..T+8; res_valid at T+27; res_p=0x008F; res_err=0; status=0x01 after the handshake.
REQ-038 Corrupt model: same operands, model returns 0x0090 -> res_err=1 and status[5]=1; status[5] stays 1 after a following good 0xFF*0xFF=0xFE01 operation.
REQ-039 Backpressure: res_ready held 0 for 10 cycles in HOLD -> res_valid=1, res_p unchanged and op_ready=0 throughout; op_ready=1 the cycle after res_ready=1.
REQ-040 Saturation: 35 back-to-back good operations -> status[4:0] reads 29 after operation 29 and stays 29.
REQ-041 Mid-operation reset: wb_rst_i=1 in SHIFT_P cycle 5 -> IDLE next cycle, no res_valid, status=0; a following 0x03*0x05 operation returns res_p=0x000F with res_err=0.
